csc_seq_ctrl: RTL and testbench

CSC_SEQ_CTRL -- requirements
Module: csc_seq_ctrl

---
 rtl/csc_ctrl_pkg.sv | 17 +
 rtl/vs_edge_det.sv | 27 ++
 rtl/csc_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_csc_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/csc_ctrl_pkg.sv
// Shared types and color-space codes for the csc sequencing controller.
package csc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_RST      = 3'd3,
    ST_WAIT_VSL = 3'd4
  } state_t;

  localparam logic [1:0] CS_RGB    = 2'd0;
  localparam logic [1:0] CS_YUV444 = 2'd1;
  localparam logic [1:0] CS_YUV422 = 2'd2;
  localparam logic [1:0] CS_YUV420 = 2'd3;

endpackage

// File: rtl/vs_edge_det.sv
// Registers vsync twice; the rising-edge strobe comes from the registered copies,
// so a VS_I edge is seen one cycle after it is first sampled.
module vs_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic vs_lvl,
  output logic vs_rise
);

  logic vs_q;
  logic vs_qq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      vs_q  <= vs;
      vs_qq <= vs_q;
    end
  end

  assign vs_lvl  = vs_q;
  assign vs_rise = vs_q & ~vs_qq;

endmodule

// File: rtl/csc_seq_ctrl.sv
// Applies csc config changes on a frame boundary: wait for vsync, drain, pulse reset,
// then release the DE gate once vsync is low. Requests are only accepted in IDLE.
module csc_seq_ctrl
  import csc_ctrl_pkg::*;
#(
  parameter int  C_PORT_NUM  = 2,
  parameter int  C_FLUSH_CYC = 8,
  parameter int  C_RST_CYC   = 4,
  localparam int PNW         = $clog2(C_PORT_NUM) + 1
) (
  input  logic           CLK_I,
  input  logic           RSTN_I,
  input  logic           CFG_VALID_I,
  output logic           CFG_READY_O,
  input  logic [1:0]     CFG_OSPACE_I,
  input  logic [PNW-1:0] CFG_PORTNUM_I,
  input  logic           VS_I,
  output logic           CSC_RST_O,
  output logic [1:0]     CSC_OSPACE_O,
  output logic [PNW-1:0] CSC_PORTNUM_O,
  output logic           DE_GATE_O,
  output logic           BUSY_O,
  output logic           CFG_ERR_O,
  output logic [15:0]    FRAME_CNT_O
);

  localparam int CNT_MAX = (C_FLUSH_CYC > C_RST_CYC) ? C_FLUSH_CYC : C_RST_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [PNW-1:0] PORT_MAX = PNW'(C_PORT_NUM);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [1:0]     shd_os;
  logic [PNW-1:0] shd_pn;
  logic [1:0]     cur_os;
  logic [PNW-1:0] cur_pn;
  logic           err_q;
  logic [15:0]    frame_q;

  logic vs_lvl;
  logic vs_rise;
  logic accept;
  logic cfg_bad;
  logic cfg_same;
  logic cfg_load;
  logic flush_done;
  logic rst_done;

  vs_edge_det u_vs_edge_det (
    .clk     (CLK_I),
    .rst_n   (RSTN_I),
    .vs      (VS_I),
    .vs_lvl  (vs_lvl),
    .vs_rise (vs_rise)
  );

  assign accept   = CFG_VALID_I && (state == ST_IDLE);
  // odd port counts cannot carry 4:2:0 chroma pairs beyond a single port
  assign cfg_bad  = (CFG_PORTNUM_I == '0) || (CFG_PORTNUM_I > PORT_MAX) ||
                    ((CFG_OSPACE_I == CS_YUV420) && CFG_PORTNUM_I[0] &&
                     (CFG_PORTNUM_I > PNW'(1)));
  assign cfg_same = (CFG_OSPACE_I == cur_os) && (CFG_PORTNUM_I == cur_pn);
  assign cfg_load = accept && !cfg_bad && !cfg_same;

  assign flush_done = (state == ST_FLUSH) && (cnt == CW'(C_FLUSH_CYC - 1));
  assign rst_done   = (state == ST_RST)   && (cnt == CW'(C_RST_CYC - 1));

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cfg_load)   state_nxt = ST_ARMED;
      ST_ARMED:    if (vs_rise)    state_nxt = ST_FLUSH;
      ST_FLUSH:    if (flush_done) state_nxt = ST_RST;
      ST_RST:      if (rst_done)   state_nxt = ST_WAIT_VSL;
      ST_WAIT_VSL: if (!vs_lvl)    state_nxt = ST_IDLE;
      default:                     state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    CFG_READY_O = (state == ST_IDLE);
    BUSY_O      = (state != ST_IDLE);
    CSC_RST_O   = (state == ST_RST);
    DE_GATE_O   = (state == ST_FLUSH) || (state == ST_RST) || (state == ST_WAIT_VSL);
  end

  // phase counter restarts on every state change so each phase is timed from zero
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == ST_FLUSH) || (state == ST_RST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      shd_os  <= CS_RGB;
      shd_pn  <= PORT_MAX;
      cur_os  <= CS_RGB;
      cur_pn  <= PORT_MAX;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      if (cfg_load) begin
        shd_os <= CFG_OSPACE_I;
        shd_pn <= CFG_PORTNUM_I;
      end
      if (flush_done) begin
        cur_os <= shd_os;
        cur_pn <= shd_pn;
      end
      err_q   <= accept && cfg_bad;
      frame_q <= frame_q + 16'(vs_rise);
    end
  end

  assign CSC_OSPACE_O  = cur_os;
  assign CSC_PORTNUM_O = cur_pn;
  assign CFG_ERR_O     = err_q;
  assign FRAME_CNT_O   = frame_q;

endmodule

// File: tb/tb_csc_seq_ctrl.sv
// Directed plus randomized bench for csc_seq_ctrl against a phase-level reference model.
module tb_csc_seq_ctrl;

  localparam int PN  = 2;
  localparam int FL  = 8;
  localparam int RC  = 4;
  localparam int PNW = $clog2(PN) + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [1:0]     cfg_os = 2'd0;
  logic [PNW-1:0] cfg_pn = '0;
  logic           vs = 1'b0;
  logic           cfg_ready;
  logic           csc_rst;
  logic [1:0]     csc_os;
  logic [PNW-1:0] csc_pn;
  logic           gate;
  logic           busy;
  logic           cfg_err;
  logic [15:0]    frame;

  int passed = 0;
  int total  = 0;

  logic [1:0]     m_os = 2'd0;
  logic [PNW-1:0] m_pn = PNW'(PN);
  logic [15:0]    m_frame = 16'd0;

  csc_seq_ctrl #(.C_PORT_NUM(PN), .C_FLUSH_CYC(FL), .C_RST_CYC(RC)) dut (
    .CLK_I         (clk),
    .RSTN_I        (rst_n),
    .CFG_VALID_I   (cfg_valid),
    .CFG_READY_O   (cfg_ready),
    .CFG_OSPACE_I  (cfg_os),
    .CFG_PORTNUM_I (cfg_pn),
    .VS_I          (vs),
    .CSC_RST_O     (csc_rst),
    .CSC_OSPACE_O  (csc_os),
    .CSC_PORTNUM_O (csc_pn),
    .DE_GATE_O     (gate),
    .BUSY_O        (busy),
    .CFG_ERR_O     (cfg_err),
    .FRAME_CNT_O   (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit m_bad(input int os, input int pn);
    return (pn == 0) || (pn > PN) || ((os == 3) && (pn % 2 == 1) && (pn > 1));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_csc_rst"}, 32'(csc_rst), 32'd1);
    chk({tag, "_gate"},    32'(gate),    32'd1);
    chk({tag, "_os"},      32'(csc_os),  32'd0);
    chk({tag, "_pn"},      32'(csc_pn),  32'(PN));
    chk({tag, "_frame"},   32'(frame),   32'd0);
    chk({tag, "_err"},     32'(cfg_err), 32'd0);
    chk({tag, "_ready"},   32'(cfg_ready), 32'd0);
    chk({tag, "_busy"},    32'(busy),    32'd1);
  endtask

  // release reset with VS low: expect RC reset cycles, then idle with default config
  task automatic release_and_settle(input string tag);
    int n;
    n = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (csc_rst) n++;
      if (!busy) break;
      tick();
    end
    m_os = 2'd0;
    m_pn = PNW'(PN);
    chk({tag, "_rst_cycles"}, 32'(n), 32'(RC));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_os"}, 32'(csc_os), 32'(m_os));
    chk({tag, "_pn"}, 32'(csc_pn), 32'(m_pn));
  endtask

  // one request, then one VS frame (hi cycles high, 6 low), checked against the model
  task automatic transact(input logic [1:0] os, input logic [PNW-1:0] pn, input string tag);
    bit bad, same, seq;
    int n_fl, n_rst, drop_t, n_busy;
    bit prev_gate, seen_rst;
    bad  = m_bad(int'(os), int'(pn));
    same = (os == m_os) && (pn == m_pn);
    seq  = !bad && !same;

    cfg_valid = 1'b1; cfg_os = os; cfg_pn = pn;
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    chk({tag, "_err"}, 32'(cfg_err), 32'(bad));
    chk({tag, "_busy"}, 32'(busy), 32'(seq));
    tick();
    chk({tag, "_err_clr"}, 32'(cfg_err), 32'd0);

    n_fl = 0; n_rst = 0; drop_t = -1; n_busy = 0; prev_gate = gate; seen_rst = 0;
    for (int t = 0; t < 26; t++) begin
      vs = (t < 20);
      tick();
      if (gate && !csc_rst && !seen_rst) n_fl++;
      if (csc_rst) begin n_rst++; seen_rst = 1; end
      if (prev_gate && !gate && drop_t < 0) drop_t = t;
      prev_gate = gate;
      if (busy) n_busy++;
    end
    vs = 1'b0;
    m_frame = m_frame + 16'd1;
    if (seq) begin
      m_os = os;
      m_pn = pn;
    end
    chk({tag, "_flush_cycles"}, 32'(n_fl), seq ? 32'(FL) : 32'd0);
    chk({tag, "_rst_cycles"}, 32'(n_rst), seq ? 32'(RC) : 32'd0);
    chk({tag, "_gate_drop_after_vs_low"}, 32'(seq ? (drop_t >= 20 && drop_t <= 22) : (drop_t < 0)), 32'd1);
    if (!seq) chk({tag, "_never_busy"}, 32'(n_busy), 32'd0);
    chk({tag, "_out_os"}, 32'(csc_os), 32'(m_os));
    chk({tag, "_out_pn"}, 32'(csc_pn), 32'(m_pn));
    chk({tag, "_idle_end"}, 32'(busy), 32'd0);
    chk({tag, "_frame"}, 32'(frame), 32'(m_frame));
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick();
    vs = 1'b0; tick();
    m_frame = m_frame + 16'd1;
  endtask

  initial begin
    // power-on reset
    tick(); tick();
    check_reset_outputs("por");
    release_and_settle("por");

    // directed: real change, invalid port count, identical config
    transact(2'd2, PNW'(1), "yuv422_p1");
    transact(2'd0, PNW'(3), "bad_pn3");
    transact(2'd2, PNW'(1), "same_cfg");

    for (int i = 0; i < 8; i++) begin
      logic [1:0]     ros;
      logic [PNW-1:0] rpn;
      ros = 2'($urandom_range(0, 3));
      rpn = PNW'($urandom_range(0, 3));
      transact(ros, rpn, $sformatf("rnd%0d", i));
    end

    // reset arriving mid-FLUSH must discard the pending request
    rst_n = 1'b0; tick(); m_frame = 16'd0;
    release_and_settle("pre_flush_rst");
    cfg_valid = 1'b1; cfg_os = 2'd1; cfg_pn = PNW'(1);
    tick();
    cfg_valid = 1'b0;
    vs = 1'b1;
    for (int i = 0; i < 12 && !(gate && !csc_rst); i++) tick();
    chk("flush_reached", 32'(gate && !csc_rst), 32'd1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    m_frame = 16'd0;
    check_reset_outputs("mid_flush");
    vs = 1'b0;
    tick(); tick();
    release_and_settle("after_flush_rst");
    transact(2'd0, PNW'(2), "shadow_gone");

    // frame counter wrap over 65537 pulses
    rst_n = 1'b0; tick(); m_frame = 16'd0;
    release_and_settle("pre_wrap");
    for (int i = 0; i < 65535; i++) vs_pulse();
    tick(); tick(); tick();
    chk("frame_ffff", 32'(frame), 32'(m_frame));
    vs_pulse(); tick(); tick(); tick();
    chk("frame_wrap0", 32'(frame), 32'(m_frame));
    vs_pulse(); tick(); tick(); tick();
    chk("frame_wrap1", 32'(frame), 32'(m_frame));
    chk("wrap_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
